// File: rtl/frontend_ctrl_pkg.sv
// Shared types for the frontend sequencer.
package frontend_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StBoot     = 3'd1,
    StRun      = 3'd2,
    StFlush    = 3'd3,
    StRedirect = 3'd4,
    StHalt     = 3'd5
  } fe_state_e;

  typedef enum logic [1:0] {
    CauseNone       = 2'd0,
    CauseMispredict = 2'd1,
    CauseException  = 2'd2
  } redirect_cause_e;

  // Width of the outstanding imem request counter.
  localparam int unsigned INFLIGHT_W = 2;

endpackage

// File: rtl/imem_inflight_tracker.sv
// Counts outstanding instruction-memory requests so a flush can wait for them to drain.
module imem_inflight_tracker
  import frontend_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ren,
  input  logic                  valid,
  output logic [INFLIGHT_W-1:0] count,
  output logic                  zero
);

  logic [INFLIGHT_W-1:0] count_q, count_d;

  // Saturate at max on issue; ignore a response when nothing is outstanding.
  always_comb begin
    count_d = count_q;
    if (ren && !valid) begin
      if (count_q != '1) count_d = count_q + INFLIGHT_W'(1);
    end else if (valid && !ren) begin
      if (count_q != '0) count_d = count_q - INFLIGHT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/frontend_ctrl.sv
// Frontend sequencer: boot, run, multi-cycle flush with imem drain, and epoch-tagged redirect.
module frontend_ctrl
  import frontend_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int unsigned     EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               halt_i,
  input  logic               decode_ready_i,
  input  logic               rename_ready_i,
  input  logic               br_mispredict_i,
  input  logic [XLEN-1:0]    br_target_i,
  input  logic               exc_i,
  input  logic [XLEN-1:0]    exc_vector_i,
  input  logic               imem_ren_i,
  input  logic               imem_valid_i,
  output logic               fetch_en_o,
  output logic               stall_o,
  output logic               redirect_en_o,
  output logic [XLEN-1:0]    redirect_pc_o,
  output logic               flush_o,
  output logic               imem_squash_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic [2:0]         state_o
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FlushLoad = CNT_W'(FLUSH_CYCLES - 1);

  fe_state_e             state_q, state_d;
  redirect_cause_e       cause_q, cause_d;
  logic [XLEN-1:0]       target_q, target_d;
  logic [XLEN-1:0]       rpc_q, rpc_d;
  logic [EPOCH_W-1:0]    epoch_q, epoch_d;
  logic [CNT_W-1:0]      fcnt_q, fcnt_d;
  logic [INFLIGHT_W-1:0] inflight_cnt;
  logic                  inflight_zero;

  imem_inflight_tracker u_tracker (
    .clk   (clk),
    .reset (reset),
    .ren   (imem_ren_i),
    .valid (imem_valid_i),
    .count (inflight_cnt),
    .zero  (inflight_zero)
  );

  // Next-state logic; exceptions win over mispredicts, which win over halt.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    target_d = target_q;
    rpc_d    = rpc_q;
    epoch_d  = epoch_q;
    fcnt_d   = fcnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StBoot;
          rpc_d   = RESET_PC;
        end
      end
      StBoot: state_d = StRun;
      StRun: begin
        if (exc_i) begin
          state_d  = StFlush;
          cause_d  = CauseException;
          target_d = {exc_vector_i[XLEN-1:2], 2'b00};
          fcnt_d   = FlushLoad;
        end else if (br_mispredict_i) begin
          state_d  = StFlush;
          cause_d  = CauseMispredict;
          target_d = {br_target_i[XLEN-1:2], 2'b00};
          fcnt_d   = FlushLoad;
        end else if (halt_i) begin
          state_d = StHalt;
        end
      end
      StFlush: begin
        // Mispredicts here come from the wrong path and are dropped.
        if (exc_i) begin
          cause_d  = CauseException;
          target_d = {exc_vector_i[XLEN-1:2], 2'b00};
          fcnt_d   = FlushLoad;
        end else if (fcnt_q != '0) begin
          fcnt_d = fcnt_q - CNT_W'(1);
        end else if (inflight_zero) begin
          state_d = StRedirect;
          rpc_d   = target_q;
          epoch_d = epoch_q + EPOCH_W'(1);
        end
      end
      StRedirect, StHalt: begin
        if (exc_i) begin
          state_d  = StFlush;
          cause_d  = CauseException;
          target_d = {exc_vector_i[XLEN-1:2], 2'b00};
          fcnt_d   = FlushLoad;
        end else if (state_q == StRedirect) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cause_q  <= CauseNone;
      target_q <= RESET_PC;
      rpc_q    <= RESET_PC;
      epoch_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      rpc_q    <= rpc_d;
      epoch_q  <= epoch_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Outputs decoded from the registered state; stall and squash follow live inputs.
  always_comb begin
    fetch_en_o    = state_q inside {StBoot, StRun, StRedirect};
    redirect_en_o = state_q inside {StBoot, StRedirect};
    flush_o       = (state_q == StFlush);
    stall_o       = (state_q == StRun) & ~(decode_ready_i & rename_ready_i);
    imem_squash_o = imem_valid_i & ((state_q == StFlush) | (state_q == StRedirect));
    redirect_pc_o = rpc_q;
    epoch_o       = epoch_q;
    state_o       = state_q;
  end

  // A redirect is only ever issued for a recorded cause.
  a_redirect_has_cause: assert property (@(posedge clk) disable iff (reset)
    (state_q == StRedirect) |-> (cause_q != CauseNone));

  // Tracker zero flag agrees with its count.
  a_inflight_zero: assert property (@(posedge clk) disable iff (reset)
    inflight_zero == (inflight_cnt == '0));

endmodule

// File: tb/tb_frontend_ctrl.sv
// Self-checking bench for frontend_ctrl: per-cycle vector table plus a redirect scoreboard.
module tb_frontend_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, halt_i, decode_ready_i, rename_ready_i;
  logic        br_mispredict_i, exc_i, imem_ren_i, imem_valid_i;
  logic [31:0] br_target_i, exc_vector_i;
  logic        fetch_en_o, stall_o, redirect_en_o, flush_o, imem_squash_o;
  logic [31:0] redirect_pc_o;
  logic [1:0]  epoch_o;
  logic [2:0]  state_o;

  frontend_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .halt_i          (halt_i),
    .decode_ready_i  (decode_ready_i),
    .rename_ready_i  (rename_ready_i),
    .br_mispredict_i (br_mispredict_i),
    .br_target_i     (br_target_i),
    .exc_i           (exc_i),
    .exc_vector_i    (exc_vector_i),
    .imem_ren_i      (imem_ren_i),
    .imem_valid_i    (imem_valid_i),
    .fetch_en_o      (fetch_en_o),
    .stall_o         (stall_o),
    .redirect_en_o   (redirect_en_o),
    .redirect_pc_o   (redirect_pc_o),
    .flush_o         (flush_o),
    .imem_squash_o   (imem_squash_o),
    .epoch_o         (epoch_o),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  // Input flags
  localparam logic [7:0] I_START = 8'h01, I_HALT = 8'h02, I_NDR = 8'h04, I_NRR = 8'h08;
  localparam logic [7:0] I_MIS = 8'h10, I_EXC = 8'h20, I_REN = 8'h40, I_VLD = 8'h80;
  // Output flags
  localparam logic [4:0] O_FE = 5'h01, O_ST = 5'h02, O_RD = 5'h04, O_FL = 5'h08, O_SQ = 5'h10;
  // Encoded states
  localparam logic [2:0] S_IDLE = 3'd0, S_BOOT = 3'd1, S_RUN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3, S_REDIR = 3'd4, S_HALT = 3'd5;

  typedef struct {
    logic [7:0]  inp;
    logic [31:0] tgt;
    logic [31:0] vec;
    logic [4:0]  out;
    logic [31:0] pc;
    logic [1:0]  ep;
    logic [2:0]  st;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ep;
  } redir_t;

  vec_t   tbl[$];
  redir_t exp_q[$];
  int     total = 0;
  int     bad   = 0;

  function automatic void add(logic [7:0] inp, logic [31:0] tgt, logic [31:0] vec,
                              logic [4:0] out, logic [31:0] pc, logic [1:0] ep, logic [2:0] st);
    vec_t v;
    v.inp = inp; v.tgt = tgt; v.vec = vec; v.out = out; v.pc = pc; v.ep = ep; v.st = st;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    start_i = 0; halt_i = 0; decode_ready_i = 1; rename_ready_i = 1;
    br_mispredict_i = 0; exc_i = 0; imem_ren_i = 0; imem_valid_i = 0;
    br_target_i = '0; exc_vector_i = '0;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d state", i), {29'd0, state_o}, {29'd0, v.st});
    chk($sformatf("v%0d fetch_en", i), {31'd0, fetch_en_o}, {31'd0, v.out[0]});
    chk($sformatf("v%0d stall", i), {31'd0, stall_o}, {31'd0, v.out[1]});
    chk($sformatf("v%0d redirect_en", i), {31'd0, redirect_en_o}, {31'd0, v.out[2]});
    chk($sformatf("v%0d flush", i), {31'd0, flush_o}, {31'd0, v.out[3]});
    chk($sformatf("v%0d squash", i), {31'd0, imem_squash_o}, {31'd0, v.out[4]});
    chk($sformatf("v%0d redirect_pc", i), redirect_pc_o, v.pc);
    chk($sformatf("v%0d epoch", i), {30'd0, epoch_o}, {30'd0, v.ep});
  endtask

  // Redirect scoreboard: every redirect pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b0 && redirect_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got redirect pc %0h want no redirect", redirect_pc_o);
      end else begin
        redir_t r;
        r = exp_q.pop_front();
        chk("sb_pc", redirect_pc_o, r.pc);
        chk("sb_epoch", {30'd0, epoch_o}, {30'd0, r.ep});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    redir_t r;
    // Boot and backpressure
    add(0, 0, 0, 0, 0, 0, S_IDLE);
    add(0, 0, 0, 0, 0, 0, S_IDLE);
    add(0, 0, 0, 0, 0, 0, S_IDLE);
    add(I_START, 0, 0, 0, 0, 0, S_IDLE);
    add(0, 0, 0, O_FE | O_RD, 0, 0, S_BOOT);
    add(0, 0, 0, O_FE, 0, 0, S_RUN);
    add(I_NRR, 0, 0, O_FE | O_ST, 0, 0, S_RUN);
    add(I_NRR, 0, 0, O_FE | O_ST, 0, 0, S_RUN);
    add(I_NRR, 0, 0, O_FE | O_ST, 0, 0, S_RUN);
    add(0, 0, 0, O_FE, 0, 0, S_RUN);
    add(I_NDR, 0, 0, O_FE | O_ST, 0, 0, S_RUN);
    // Mispredict to 0x103 -> 0x100
    add(I_MIS, 32'h103, 0, O_FE, 0, 0, S_RUN);
    add(0, 0, 0, O_FL, 0, 0, S_FLUSH);
    add(0, 0, 0, O_FL, 0, 0, S_FLUSH);
    add(0, 0, 0, O_FE | O_RD, 32'h100, 1, S_REDIR);
    add(0, 0, 0, O_FE, 32'h100, 1, S_RUN);
    // Exception beats simultaneous mispredict
    add(I_EXC | I_MIS, 32'h40, 32'h800, O_FE, 32'h100, 1, S_RUN);
    add(0, 0, 0, O_FL, 32'h100, 1, S_FLUSH);
    add(0, 0, 0, O_FL, 32'h100, 1, S_FLUSH);
    add(0, 0, 0, O_FE | O_RD, 32'h800, 2, S_REDIR);
    add(0, 0, 0, O_FE, 32'h800, 2, S_RUN);
    // Mispredict in FLUSH ignored; exception at counter 0 reloads
    add(I_MIS, 32'h200, 0, O_FE, 32'h800, 2, S_RUN);
    add(I_MIS, 32'h44, 0, O_FL, 32'h800, 2, S_FLUSH);
    add(I_EXC, 0, 32'h903, O_FL, 32'h800, 2, S_FLUSH);
    add(0, 0, 0, O_FL, 32'h800, 2, S_FLUSH);
    add(0, 0, 0, O_FL, 32'h800, 2, S_FLUSH);
    add(0, 0, 0, O_FE | O_RD, 32'h900, 3, S_REDIR);
    add(0, 0, 0, O_FE, 32'h900, 3, S_RUN);
    // In-flight request extends FLUSH; epoch wraps to 0
    add(I_REN | I_MIS, 32'h300, 0, O_FE, 32'h900, 3, S_RUN);
    add(0, 0, 0, O_FL, 32'h900, 3, S_FLUSH);
    add(0, 0, 0, O_FL, 32'h900, 3, S_FLUSH);
    add(I_VLD, 0, 0, O_FL | O_SQ, 32'h900, 3, S_FLUSH);
    add(0, 0, 0, O_FL, 32'h900, 3, S_FLUSH);
    add(I_VLD, 0, 0, O_FE | O_RD | O_SQ, 32'h300, 0, S_REDIR);
    add(I_VLD, 0, 0, O_FE, 32'h300, 0, S_RUN);
    // Halt, then exception out of HALT
    add(I_HALT, 0, 0, O_FE, 32'h300, 0, S_RUN);
    add(I_START | I_HALT, 0, 0, 0, 32'h300, 0, S_HALT);
    add(I_NDR, 0, 0, 0, 32'h300, 0, S_HALT);
    add(I_MIS, 32'h600, 0, 0, 32'h300, 0, S_HALT);
    add(I_EXC, 0, 32'h804, 0, 32'h300, 0, S_HALT);
    add(0, 0, 0, O_FL, 32'h300, 0, S_FLUSH);
    add(0, 0, 0, O_FL, 32'h300, 0, S_FLUSH);
    add(I_MIS, 32'h700, 0, O_FE | O_RD, 32'h804, 1, S_REDIR);
    add(0, 0, 0, O_FE, 32'h804, 1, S_RUN);
    // Enter FLUSH, then reset mid-flush below
    add(I_MIS, 32'h500, 0, O_FE, 32'h804, 1, S_RUN);
    add(0, 0, 0, O_FL, 32'h804, 1, S_FLUSH);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", {29'd0, state_o}, 32'd0);
    chk("reset outputs", {27'd0, fetch_en_o, stall_o, redirect_en_o, flush_o, imem_squash_o}, 32'd0);
    chk("reset pc", redirect_pc_o, 32'h0);
    chk("reset epoch", {30'd0, epoch_o}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      start_i         = tbl[i].inp[0];
      halt_i          = tbl[i].inp[1];
      decode_ready_i  = ~tbl[i].inp[2];
      rename_ready_i  = ~tbl[i].inp[3];
      br_mispredict_i = tbl[i].inp[4];
      exc_i           = tbl[i].inp[5];
      imem_ren_i      = tbl[i].inp[6];
      imem_valid_i    = tbl[i].inp[7];
      br_target_i     = tbl[i].tgt;
      exc_vector_i    = tbl[i].vec;
      if (tbl[i].out[2]) begin
        r.pc = tbl[i].pc; r.ep = tbl[i].ep;
        exp_q.push_back(r);
      end
      @(negedge clk);
      check_vec(i, tbl[i]);
    end

    // Asynchronous reset in the middle of FLUSH
    #2;
    drive_idle();
    reset = 1'b1;
    #1;
    chk("midflush state", {29'd0, state_o}, {29'd0, S_IDLE});
    chk("midflush flush", {31'd0, flush_o}, 32'd0);
    chk("midflush pc", redirect_pc_o, 32'h0);
    chk("midflush epoch", {30'd0, epoch_o}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    r.pc = 32'h0; r.ep = 2'd0;
    exp_q.push_back(r);
    @(negedge clk);
    chk("reboot state", {29'd0, state_o}, {29'd0, S_BOOT});
    chk("reboot pc", redirect_pc_o, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("after reboot %0d state", k), {29'd0, state_o}, {29'd0, S_RUN});
      chk($sformatf("after reboot %0d pc", k), redirect_pc_o, 32'h0);
      chk($sformatf("after reboot %0d flush", k), {31'd0, flush_o}, 32'd0);
    end

    chk("sb pending", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frontend_ctrl.md
Name: frontend_ctrl

Overview:
Central sequencer for the fetch/decode/rename frontend. It drives fetch enable, stall and redirect into fetch, and a flush into the decode and rename pipeline registers. On a branch mispredict or exception it runs a multi-cycle flush. During the flush it drains and squashes in-flight instruction-memory responses, then issues one redirect pulse with a new fetch epoch. It sits between the execute/commit stages, which raise the events, and the fetch, decode and rename stages.

Parameters:
XLEN, 32, address width
FLUSH_CYCLES, 2, minimum cycles flush_o is held (>=1)
RESET_PC, 32'h0, boot fetch address
EPOCH_W, 2, fetch epoch counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start_i  in  1  boot request; leave IDLE
halt_i  in  1  stop fetching (sampled in RUN)
decode_ready_i  in  1  decode can accept
rename_ready_i  in  1  rename can accept
br_mispredict_i  in  1  execute mispredict pulse
br_target_i  in  XLEN  corrected PC
exc_i  in  1  commit exception pulse
exc_vector_i  in  XLEN  handler PC
imem_ren_i  in  1  fetch issued an imem request this cycle
imem_valid_i  in  1  imem response this cycle
fetch_en_o  out  1  to fetch
stall_o  out  1  to fetch
redirect_en_o  out  1  one-cycle redirect pulse to fetch
redirect_pc_o  out  XLEN  redirect target
flush_o  out  1  clear decode/rename valid bits
imem_squash_o  out  1  drop the current imem response
epoch_o  out  EPOCH_W  current fetch epoch
state_o  out  3  encoded FSM state (debug)

Behaviour:
- Reset (asynchronous): state=IDLE; all 1-bit outputs 0; redirect_pc_o=RESET_PC; epoch_o=0; inflight=0; flush counter=0; pending target=RESET_PC; pending cause=NONE.
- States: IDLE, BOOT, RUN, FLUSH, REDIRECT, HALT. Outputs decode from registered state. Only stall_o and imem_squash_o are combinational.
- IDLE: fetch_en_o=0. start_i -> BOOT.
- BOOT: for 1 cycle, redirect_en_o=1, redirect_pc_o=RESET_PC, fetch_en_o=1. Next state is RUN. epoch is not changed.
- RUN: fetch_en_o=1; stall_o = ~(decode_ready_i & rename_ready_i).
- Event priority in RUN: exc_i > br_mispredict_i > halt_i.
  - exc_i or br_mispredict_i: latch the target with bits [1:0] forced to 0, latch the cause, load counter=FLUSH_CYCLES-1, go to FLUSH.
  - halt_i alone: go to HALT.
- In all states other than RUN, stall_o=0.
- FLUSH: flush_o=1, fetch_en_o=0. Counter decrements to 0 and saturates there.
  - Exit to REDIRECT when counter==0 and inflight==0.
  - exc_i in FLUSH: replaces target and cause, reloads the counter.
  - br_mispredict_i in FLUSH is ignored (wrong path).
- REDIRECT: for 1 cycle, redirect_en_o=1, fetch_en_o=1, redirect_pc_o=latched target. epoch_o increments and wraps modulo 2^EPOCH_W. Next state is RUN.
  - exc_i in REDIRECT: go to FLUSH with the new target.
  - br_mispredict_i in REDIRECT is ignored.
- HALT: fetch_en_o=0. Only exc_i leaves HALT, going to FLUSH. start_i and halt_i are ignored.
- redirect_pc_o holds its last value outside redirect pulses.
- Inflight tracker: 2-bit saturating counter.
  - +1 on imem_ren_i, -1 on imem_valid_i.
  - Both in the same cycle: no change.
  - Decrement at 0 is ignored.
- imem_squash_o = imem_valid_i & (state==FLUSH | state==REDIRECT).
- Timing with FLUSH_CYCLES=2, event sampled at the edge ending cycle N, no inflight:
  - flush_o high in N+1 and N+2.
  - redirect_en_o in N+3.
  - fetch_en_o remains high from N+3 through the return to RUN at N+4.
- Reset asserted mid-FLUSH: immediate return to IDLE; the pending target is discarded.

Decomposition:
- Package frontend_ctrl_pkg:
  - fe_state_e (IDLE=0, BOOT=1, RUN=2, FLUSH=3, REDIRECT=4, HALT=5)
  - redirect_cause_e (NONE, MISPREDICT, EXCEPTION)
  - localparam INFLIGHT_W=2
- One sub-module: imem_inflight_tracker (counter with saturation/underflow rules, outputs inflight count and the zero flag).

Test Plan:
- Reset, then start_i in cycle 3 -> BOOT in cycle 4 with redirect_en_o=1, redirect_pc_o=0; RUN from cycle 5 with fetch_en_o=1; all other outputs at reset values before that.
- RUN, rename_ready_i=0 for 3 cycles -> stall_o=1 for exactly those 3 cycles, fetch_en_o stays 1, no state change.
- Mispredict at cycle N, br_target_i=0x103 -> flush_o in N+1..N+2; redirect_en_o in N+3 with pc 0x100; epoch_o becomes 1; RUN at N+4.
- exc_i (vector 0x800) with br_mispredict_i (0x40) in the same cycle -> target 0x800, cause EXCEPTION.
  - Later, mispredict during FLUSH is ignored.
  - exc_i (0x900) at FLUSH counter==0 reloads the counter; redirect goes to 0x900.
- Request in flight at flush entry, response 3 cycles later -> FLUSH is extended until that response; imem_squash_o=1 on that response cycle.
- Four redirects -> epoch 1,2,3,0 (wrap).
- halt_i -> HALT, fetch_en_o=0; then exc_i -> FLUSH/REDIRECT to the vector.
- reset asserted mid-FLUSH -> IDLE immediately.
